// File: rtl/downstream_req_arbiter_if.sv
// Request/RAM/response bundle for downstream_req_arbiter.
// The arbiter uses the slave view; the requesters, RAM and response consumer use the master view.
interface downstream_req_arbiter_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_wr;
  logic [N_REQ*5-1:0]  req_client;
  logic [N_REQ*16-1:0] req_amount;
  logic [4:0]          ram_index;
  logic                ram_we;
  logic [127:0]        ram_wdata;
  logic [127:0]        ram_rdata;
  logic                rsp_valid;
  logic [2:0]          rsp_id;
  logic [15:0]         rsp_data;
  logic                rsp_skip;
  logic                busy;

  modport slave (
    input  req_valid, req_wr, req_client, req_amount, ram_rdata,
    output req_ready, ram_index, ram_we, ram_wdata, rsp_valid, rsp_id, rsp_data, rsp_skip, busy
  );
  modport master (
    output req_valid, req_wr, req_client, req_amount, ram_rdata,
    input  req_ready, ram_index, ram_we, ram_wdata, rsp_valid, rsp_id, rsp_data, rsp_skip, busy
  );
endinterface

// File: rtl/downstream_req_arbiter.sv
// Round-robin arbiter sharing the single port of the downstream cancelled-orders RAM; one op in flight.
// Optional: define DS_DEDUP_EN to suppress writes that repeat the last amount written to an index.
module downstream_req_arbiter #(
  parameter int N_REQ  = 4,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst,
  downstream_req_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  rr_ptr_q, rr_ptr_d;
  logic [2:0]  id_q, id_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [4:0]  client_q, client_d;
  logic [15:0] amt_q, amt_d;
  logic [15:0] rsp_data_q, rsp_data_d;
  logic        wr_q, wr_d;
  logic        skip_q, skip_d;
  logic        found;
  logic [2:0]  gnt;
  logic        dup;
  logic [N_REQ-1:0] ready;
  logic        we;

  // Search from rr_ptr upward with wrap; first valid requester wins.
  always_comb begin
    int idx;
    found = 1'b0;
    gnt   = rr_ptr_q;
    idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gnt   = 3'(idx);
      end
    end
  end

`ifdef DS_DEDUP_EN
  logic [15:0] shadow_q [32];
  logic [31:0] shadow_vld_q, shadow_vld_d;
  logic        shadow_we;

  assign dup       = wr_q && shadow_vld_q[client_q] && (shadow_q[client_q] == amt_q);
  assign shadow_we = (state_q == ISSUE) && wr_q && !dup;

  always_comb begin
    shadow_vld_d = shadow_vld_q;
    if (shadow_we) shadow_vld_d[client_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) shadow_vld_q <= '0;
    else     shadow_vld_q <= shadow_vld_d;

  // Data array needs no reset: entries are only trusted once their valid bit is set.
  always_ff @(posedge clk)
    if (shadow_we) shadow_q[client_q] <= amt_q;
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    client_d   = client_q;
    amt_d      = amt_q;
    wr_d       = wr_q;
    skip_d     = skip_q;
    rsp_data_d = rsp_data_q;
    ready      = '0;
    we         = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        ready[gnt] = 1'b1;
        client_d   = bus.req_client[5*gnt +: 5];
        amt_d      = bus.req_amount[16*gnt +: 16];
        wr_d       = bus.req_wr[gnt];
        id_d       = gnt;
        rr_ptr_d   = (int'(gnt) == N_REQ-1) ? 3'd0 : gnt + 3'd1;
        state_d    = ISSUE;
      end
      ISSUE: begin
        we      = wr_q && !dup;
        skip_d  = wr_q && dup;
        cnt_d   = 3'(RD_LAT-1);
        state_d = WAIT;
      end
      WAIT: begin
        // Last wait cycle is the first one with ram_rdata valid; latch the response here.
        if (cnt_q == 3'd0) begin
          rsp_data_d = wr_q ? amt_q : bus.ram_rdata[15:0];
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      client_q   <= '0;
      amt_q      <= '0;
      wr_q       <= 1'b0;
      skip_q     <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      client_q   <= client_d;
      amt_q      <= amt_d;
      wr_q       <= wr_d;
      skip_q     <= skip_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.ram_we    = we;
  assign bus.ram_index = client_q;
  assign bus.ram_wdata = {112'b0, amt_q};
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_skip  = skip_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_downstream_req_arbiter.sv
// Directed bench for downstream_req_arbiter: u0 with RD_LAT=1, u1 with RD_LAT=3, each with its own RAM model.
module tb_downstream_req_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

`ifdef DS_DEDUP_EN
  localparam logic DEDUP = 1'b1;
`else
  localparam logic DEDUP = 1'b0;
`endif

  always #5 clk = ~clk;

  downstream_req_arbiter_if #(.N_REQ(4)) b0();
  downstream_req_arbiter_if #(.N_REQ(4)) b1();

  downstream_req_arbiter #(.N_REQ(4), .RD_LAT(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  downstream_req_arbiter #(.N_REQ(4), .RD_LAT(3)) u1 (.clk(clk), .rst(rst), .bus(b1));

  // RAM models: entry i preloaded with 0x1000+i while rst is high; read pipeline RD_LAT deep.
  logic [127:0] mem0 [32];
  logic [127:0] mem1 [32];
  logic [127:0] rp0  [4];
  logic [127:0] rp1  [4];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem0[i] <= {112'b0, 16'h1000 + 16'(i)};
        mem1[i] <= {112'b0, 16'h1000 + 16'(i)};
      end
    end else begin
      if (b0.ram_we) mem0[b0.ram_index] <= b0.ram_wdata;
      if (b1.ram_we) mem1[b1.ram_index] <= b1.ram_wdata;
    end
    rp0[0] <= mem0[b0.ram_index];
    rp1[0] <= mem1[b1.ram_index];
    for (int k = 1; k < 4; k++) begin
      rp0[k] <= rp0[k-1];
      rp1[k] <= rp1[k-1];
    end
  end
  assign b0.ram_rdata = rp0[0];
  assign b1.ram_rdata = rp1[2];

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one request on u0 from an IDLE cycle T and records observations at T, T+1, T+2, T+3.
  task automatic run_op0(input int id, input logic wr, input logic [4:0] cl, input logic [15:0] am,
                         output logic [3:0] rdy, output logic we1, output logic [4:0] idx1,
                         output logic [15:0] wd1, output logic we2, output logic rv2,
                         output logic rv3, output logic [2:0] rid, output logic [15:0] rdat,
                         output logic rsk);
    b0.req_valid[id] = 1'b1;
    b0.req_wr[id] = wr;
    b0.req_client[5*id +: 5] = cl;
    b0.req_amount[16*id +: 16] = am;
    #1 rdy = b0.req_ready;
    step();
    we1 = b0.ram_we; idx1 = b0.ram_index; wd1 = b0.ram_wdata[15:0];
    b0.req_valid[id] = 1'b0;
    step();
    we2 = b0.ram_we; rv2 = b0.rsp_valid;
    step();
    rv3 = b0.rsp_valid; rid = b0.rsp_id; rdat = b0.rsp_data; rsk = b0.rsp_skip;
    step();
  endtask

  logic [3:0]  rdy;
  logic        we1, we2, rv2, rv3, rsk;
  logic [4:0]  idx1;
  logic [15:0] wd1, rdat;
  logic [2:0]  rid;

  task automatic test_reset();
    step(); step();
    n_cmp++; if (b0.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", b0.busy); end
    n_cmp++; if (b0.ram_we !== 1'b0 || b0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_we_rsp got %b%b want 00", b0.ram_we, b0.rsp_valid); end
    n_cmp++; if (b0.ram_index !== 5'd0 || b0.ram_wdata !== 128'd0 || b0.rsp_data !== 16'd0) begin n_bad++; $display("FAIL reset_regs got idx %0d wd %h rd %h want 0", b0.ram_index, b0.ram_wdata, b0.rsp_data); end
    n_cmp++; if (b0.req_ready !== 4'b0000 || b0.rsp_skip !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %b/%b want 0000/0", b0.req_ready, b0.rsp_skip); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_rst_mid_wait();
    b0.req_valid[1] = 1'b1; b0.req_wr[1] = 1'b1; b0.req_client[9:5] = 5'd20; b0.req_amount[31:16] = 16'h0BAD;
    step();
    b0.req_valid[1] = 1'b0;
    step();
    n_cmp++; if (b0.busy !== 1'b1) begin n_bad++; $display("FAIL t1_busy_in_wait got %b want 1", b0.busy); end
    rst = 1'b1;
    #1;
    n_cmp++; if (b0.busy !== 1'b0 || b0.ram_we !== 1'b0 || b0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_abort got busy %b we %b rv %b want 000", b0.busy, b0.ram_we, b0.rsp_valid); end
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if (b0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t1_no_rsp cycle %0d got %b want 0", c, b0.rsp_valid); end
    end
    b0.req_valid = 4'b0101; b0.req_wr = 4'b0000; b0.req_client = '0;
    #1;
    n_cmp++; if (b0.req_ready !== 4'b0001) begin n_bad++; $display("FAIL t1_rr_after_rst got %b want 0001", b0.req_ready); end
    step();
    b0.req_valid = 4'b0000;
    step(); step(); step();
  endtask

  task automatic test_write();
    run_op0(1, 1'b1, 5'd5, 16'h00A3, rdy, we1, idx1, wd1, we2, rv2, rv3, rid, rdat, rsk);
    n_cmp++; if (rdy !== 4'b0010) begin n_bad++; $display("FAIL t2_ready got %b want 0010", rdy); end
    n_cmp++; if (we1 !== 1'b1 || idx1 !== 5'd5 || wd1 !== 16'h00A3) begin n_bad++; $display("FAIL t2_issue got we %b idx %0d wd %h want 1 5 00a3", we1, idx1, wd1); end
    n_cmp++; if (we2 !== 1'b0 || rv2 !== 1'b0) begin n_bad++; $display("FAIL t2_wait got we %b rv %b want 0 0", we2, rv2); end
    n_cmp++; if (rv3 !== 1'b1 || rid !== 3'd1 || rdat !== 16'h00A3 || rsk !== 1'b0) begin n_bad++; $display("FAIL t2_rsp got v %b id %0d d %h s %b want 1 1 00a3 0", rv3, rid, rdat, rsk); end
    n_cmp++; if (b0.busy !== 1'b0 || b0.rsp_valid !== 1'b0) begin n_bad++; $display("FAIL t2_idle got busy %b rv %b want 0 0", b0.busy, b0.rsp_valid); end
  endtask

  task automatic test_read();
    run_op0(2, 1'b0, 5'd5, 16'hFFFF, rdy, we1, idx1, wd1, we2, rv2, rv3, rid, rdat, rsk);
    n_cmp++; if (rdy !== 4'b0100) begin n_bad++; $display("FAIL t3_ready got %b want 0100", rdy); end
    n_cmp++; if (we1 !== 1'b0 || we2 !== 1'b0 || idx1 !== 5'd5) begin n_bad++; $display("FAIL t3_no_we got we %b%b idx %0d want 00 5", we1, we2, idx1); end
    n_cmp++; if (rv3 !== 1'b1 || rid !== 3'd2 || rdat !== 16'h00A3) begin n_bad++; $display("FAIL t3_rsp got v %b id %0d d %h want 1 2 00a3", rv3, rid, rdat); end
  endtask

  task automatic test_rotation();
    int n;
    int last;
    logic [2:0] ids [5];
    rst = 1'b1; step(); rst = 1'b0;
    b0.req_wr = 4'b0000;
    for (int i = 0; i < 4; i++) b0.req_client[5*i +: 5] = 5'(i + 1);
    b0.req_valid = 4'b1111;
    #1;
    n_cmp++; if (b0.req_ready !== 4'b0001) begin n_bad++; $display("FAIL t4_first_ready got %b want 0001", b0.req_ready); end
    n = 0; last = 0;
    for (int c = 1; c <= 40 && n < 5; c++) begin
      step();
      n_cmp++; if (b0.ram_we !== 1'b0) begin n_bad++; $display("FAIL t4_we cycle %0d got 1 want 0", c); end
      if (b0.rsp_valid === 1'b1) begin
        ids[n] = b0.rsp_id;
        n_cmp++; if (c - last !== ((n == 0) ? 3 : 4)) begin n_bad++; $display("FAIL t4_spacing rsp %0d got %0d want %0d", n, c - last, (n == 0) ? 3 : 4); end
        n_cmp++; if (b0.rsp_data !== 16'h1001 + 16'(ids[n])) begin n_bad++; $display("FAIL t4_data rsp %0d got %h want %h", n, b0.rsp_data, 16'h1001 + 16'(ids[n])); end
        last = c;
        n++;
      end
    end
    b0.req_valid = 4'b0000;
    n_cmp++; if (n !== 5) begin n_bad++; $display("FAIL t4_count got %0d want 5", n); end
    for (int i = 0; i < n; i++) begin
      n_cmp++; if (ids[i] !== 3'(i % 4)) begin n_bad++; $display("FAIL t4_order grant %0d got %0d want %0d", i, ids[i], i % 4); end
    end
    step();
  endtask

  task automatic test_rd_lat3();
    b1.req_valid[0] = 1'b1; b1.req_wr[0] = 1'b0; b1.req_client[4:0] = 5'd12; b1.req_amount[15:0] = 16'h5555;
    #1;
    n_cmp++; if (b1.req_ready !== 4'b0001) begin n_bad++; $display("FAIL t5_ready got %b want 0001", b1.req_ready); end
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c == 1) begin
        b1.req_valid[0] = 1'b0; b1.req_wr[0] = 1'b1; b1.req_client[4:0] = 5'd7; b1.req_amount[15:0] = 16'hBEEF;
      end
      n_cmp++; if (b1.rsp_valid !== (c == 5)) begin n_bad++; $display("FAIL t5_rsp_valid T+%0d got %b want %b", c, b1.rsp_valid, c == 5); end
      n_cmp++; if (b1.ram_we !== 1'b0 || b1.ram_index !== 5'd12) begin n_bad++; $display("FAIL t5_ram T+%0d got we %b idx %0d want 0 12", c, b1.ram_we, b1.ram_index); end
    end
    n_cmp++; if (b1.rsp_data !== 16'h100C || b1.rsp_id !== 3'd0) begin n_bad++; $display("FAIL t5_rsp_data got %h id %0d want 100c 0", b1.rsp_data, b1.rsp_id); end
    step();
  endtask

  task automatic test_dedup();
    run_op0(0, 1'b1, 5'd9, 16'h0007, rdy, we1, idx1, wd1, we2, rv2, rv3, rid, rdat, rsk);
    n_cmp++; if (we1 !== 1'b1 || rv3 !== 1'b1 || rsk !== 1'b0) begin n_bad++; $display("FAIL t6_first got we %b v %b skip %b want 1 1 0", we1, rv3, rsk); end
    run_op0(0, 1'b1, 5'd9, 16'h0007, rdy, we1, idx1, wd1, we2, rv2, rv3, rid, rdat, rsk);
    n_cmp++; if (we1 !== !DEDUP || rsk !== DEDUP) begin n_bad++; $display("FAIL t6_second got we %b skip %b want %b %b", we1, rsk, !DEDUP, DEDUP); end
    n_cmp++; if (rv3 !== 1'b1 || rdat !== 16'h0007) begin n_bad++; $display("FAIL t6_second_rsp got v %b d %h want 1 0007", rv3, rdat); end
    rst = 1'b1; step(); rst = 1'b0;
    run_op0(0, 1'b1, 5'd9, 16'h0007, rdy, we1, idx1, wd1, we2, rv2, rv3, rid, rdat, rsk);
    n_cmp++; if (we1 !== 1'b1 || rsk !== 1'b0) begin n_bad++; $display("FAIL t6_after_rst got we %b skip %b want 1 0", we1, rsk); end
  endtask

  initial begin
    b0.req_valid = '0; b0.req_wr = '0; b0.req_client = '0; b0.req_amount = '0;
    b1.req_valid = '0; b1.req_wr = '0; b1.req_client = '0; b1.req_amount = '0;
    test_reset();
    test_rst_mid_wait();
    test_write();
    test_read();
    test_rotation();
    test_rd_lat3();
    test_dedup();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
